// File: rtl/char_map_ctrl.sv
// Character-code map for the text overlay: 1-cycle registered lookups for the
// renderer, plus single-cell writes and whole-map clears committed in vblank.
//
// Ports:
//   clk        pixel clock
//   rst        synchronous reset, active-high
//   vblnk      vertical blank; gates the start of writes/clears
//   char_xy    renderer lookup address (col + COLS*row)
//   char_code  registered code at char_xy (CLEAR_CODE when out of range)
//   wr_req     cell write request, held until wr_ack
//   wr_addr    cell address for the write
//   wr_code    code to write
//   wr_ack     1-cycle pulse when the write is done
//   clr_req    map clear request, held until clr_ack
//   clr_ack    1-cycle pulse when the clear sweep is done
//   busy       high while a clear sweep (power-up or requested) runs
module char_map_ctrl #(
    parameter int unsigned       COLS       = 8,
    parameter int unsigned       ROWS       = 16,
    parameter int unsigned       CODE_W     = 6,
    parameter logic [CODE_W-1:0] CLEAR_CODE = '0,
    parameter bit                SYNC_BLANK = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vblnk,
    input  logic [7:0]        char_xy,
    output logic [CODE_W-1:0] char_code,
    input  logic              wr_req,
    input  logic [7:0]        wr_addr,
    input  logic [CODE_W-1:0] wr_code,
    output logic              wr_ack,
    input  logic              clr_req,
    output logic              clr_ack,
    output logic              busy
);

    localparam int unsigned DEPTH = COLS * ROWS;
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    typedef enum logic [2:0] {
        INIT_CLR,
        IDLE,
        WR_ACK,
        CLR,
        CLR_ACK
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [CODE_W-1:0] mem_q [DEPTH];
    logic [CODE_W-1:0] char_code_q;
    logic              wr_ack_q, clr_ack_q, busy_q;

    logic              gate;
    logic              rd_in_rng;
    logic              wr_in_rng;
    logic              mem_we;
    logic [AW-1:0]     mem_waddr;
    logic [CODE_W-1:0] mem_wdata;

    assign gate      = vblnk | !SYNC_BLANK;
    assign rd_in_rng = {1'b0, char_xy} < 9'(DEPTH);
    assign wr_in_rng = {1'b0, wr_addr} < 9'(DEPTH);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        mem_we    = 1'b0;
        mem_waddr = addr_q;
        mem_wdata = CLEAR_CODE;
        unique case (state_q)
            INIT_CLR, CLR: begin
                // Sweep runs to completion regardless of gate or requests.
                mem_we = 1'b1;
                addr_d = addr_q + 1'b1;
                if (addr_q == LAST) begin
                    addr_d  = '0;
                    state_d = (state_q == CLR) ? CLR_ACK : IDLE;
                end
            end
            IDLE: begin
                // Clear outranks a simultaneous write; the write waits.
                if (clr_req && gate) begin
                    addr_d  = '0;
                    state_d = CLR;
                end else if (wr_req && gate) begin
                    mem_we    = wr_in_rng;
                    mem_waddr = wr_addr[AW-1:0];
                    mem_wdata = wr_code;
                    state_d   = WR_ACK;
                end
            end
            WR_ACK, CLR_ACK: state_d = IDLE;
            default:         state_d = INIT_CLR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= INIT_CLR;
            addr_q    <= '0;
            wr_ack_q  <= 1'b0;
            clr_ack_q <= 1'b0;
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            // Flags follow the state they describe, cycle for cycle.
            wr_ack_q  <= (state_d == WR_ACK);
            clr_ack_q <= (state_d == CLR_ACK);
            busy_q    <= (state_d == INIT_CLR) || (state_d == CLR);
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // Non-blocking read of mem_q gives the old value on a same-cycle write.
    always_ff @(posedge clk) begin
        if (rst) begin
            char_code_q <= '0;
        end else if (rd_in_rng) begin
            char_code_q <= mem_q[char_xy[AW-1:0]];
        end else begin
            char_code_q <= CLEAR_CODE;
        end
    end

    assign char_code = char_code_q;
    assign wr_ack    = wr_ack_q;
    assign clr_ack   = clr_ack_q;
    assign busy      = busy_q;

endmodule
